// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request at a time, fixed WAIT latency,
// RV32 load extension and byte/half/word stores committed on the WAIT->RESP edge.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          resp_valid_q;
    logic [31:0]   rdata_q;
    logic          error_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx_s;
    logic [31:0]   mem_word_s;
    logic [31:0]   merged_s;
    logic          commit_s;
    logic          mem_we_s;
    logic [31:0]   rdata_d;
    logic          error_d;

    function automatic logic access_illegal(input logic wr, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [29:0] depth);
        logic bad;
        case (f3)
            3'd0:       bad = 1'b0;
            3'd4:       bad = wr;
            3'd1:       bad = a[0];
            3'd5:       bad = a[0] | wr;
            3'd2:       bad = (a[1:0] != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad | (a[31:2] >= depth);
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'd0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'd0, h};
            3'd2:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] m;
        m = old;
        case (f3)
            3'd0: m[{lane, 3'b000} +: 8] = wd[7:0];
            3'd1: begin
                if (lane[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0] = wd[15:0];
                end
            end
            3'd2:    m = wd;
            default: m = old;
        endcase
        return m;
    endfunction

    // Access decode on the latched request: legality, read data and merged store word.
    always_comb begin
        word_idx_s = addr_q[AW+1:2];
        mem_word_s = mem_q[word_idx_s];
        error_d    = access_illegal(write_q, funct3_q, addr_q, DEPTH_L);
        rdata_d    = (error_d || write_q) ? 32'd0 : load_extend(funct3_q, addr_q[1:0], mem_word_s);
        merged_s   = store_merge(funct3_q, addr_q[1:0], mem_word_s, wdata_q);
        commit_s   = (state_q == S_WAIT) && (cnt_q == 4'd0);
        mem_we_s   = commit_s && write_q && !error_d && !reset;
    end

    // Control FSM with registered response outputs; reset clears control state only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= LAT_M1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q      <= rdata_d;
                        error_q      <= error_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rdata_q      <= 32'd0;
                        error_q      <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    cnt_q        <= 4'd0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array, deliberately outside reset so contents survive it.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[word_idx_s] <= merged_s;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset corner
// sequences and randomized traffic against a byte-array reference model.
module tb_dmem_responder;

    localparam int D   = 64;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int checks = 0;
    int failures = 0;

    logic [7:0] bmem [4*D];

    dmem_responder #(.DEPTH_WORDS(D), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=0x%08h req=0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: byte memory with rules written directly from the ISA semantics.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int size;
        bit legal;
        longint v;
        if (w) legal = (f3 <= 3'd2);
        else   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        err = !legal || ((a % size) != 0) || (longint'(a) >= longint'(4*D));
        rd = 32'd0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < size; i++) bmem[a+i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v | (longint'(bmem[a+i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = (hold == 0);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("latency", 32'(n), 32'(LAT + 1));
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        rd = resp_rdata;
        er = resp_error;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_error", {31'd0, resp_error}, {31'd0, er});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        chk("post_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int hold);
        logic [31:0] erd, ard;
        logic        eer, aer;
        model(w, f3, a, wd, erd, eer);
        txn(w, f3, a, wd, hold, ard, aer);
        chk("model_rdata", ard, erd);
        chk("model_error", {31'd0, aer}, {31'd0, eer});
    endtask

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] ard, mrd, prior;
        logic        aer, mer;

        vecs.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 4'd0});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'd5});
        vecs.push_back('{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 4'd0});
        vecs.push_back('{1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0, 4'd0});
        vecs.push_back('{1'b0, 3'd1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 4'd1});
        vecs.push_back('{1'b0, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 3'd0, 32'h11, 32'hFFFFFF55, 32'h0,        1'b0, 4'd0});
        vecs.push_back('{1'b1, 3'd1, 32'h12, 32'hABCD1234, 32'h0,        1'b0, 4'd0});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 1'b0, 4'd0});
        vecs.push_back('{1'b0, 3'd2, 32'h12, 32'h0,        32'h0,        1'b1, 4'd0});
        vecs.push_back('{1'b1, 3'd1, 32'h11, 32'h9999,     32'h0,        1'b1, 4'd3});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 1'b0, 4'd0});
        vecs.push_back('{1'b0, 3'd2, 32'(4*D), 32'h0,      32'h0,        1'b1, 4'd0});
        vecs.push_back('{1'b0, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1, 4'd0});
        vecs.push_back('{1'b1, 3'd4, 32'h10, 32'h77,       32'h0,        1'b1, 4'd0});
        vecs.push_back('{1'b0, 3'd4, 32'h11, 32'h0,        32'h00000055, 1'b0, 4'd0});

        // Reset held two cycles.
        @(negedge clock);
        chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        foreach (vecs[i]) begin
            model(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mer);
            txn(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, int'(vecs[i].hold), ard, aer);
            chk($sformatf("vec%0d_rdata", i), ard, vecs[i].exp_rd);
            chk($sformatf("vec%0d_error", i), {31'd0, aer}, {31'd0, vecs[i].exp_err});
        end

        for (int i = 0; i < D; i++) run_model(1'b1, 3'd2, 32'(4*i), $urandom, 0);

        // Store aborted by reset on its commit edge.
        model(1'b0, 3'd2, 32'h20, 32'h0, prior, mer);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_ready_back", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 3'd2, 32'h20, 32'h0, 0, ard, aer);
        chk("abort_prior_word", ard, prior);
        chk("abort_prior_err", {31'd0, aer}, 32'd0);

        // Reset while the response is pending drops it.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clock);
        chk("resp_pending", {31'd0, resp_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("resp_dropped", {31'd0, resp_valid}, 32'd0);
        chk("resp_dropped_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        chk("drop_ready_back", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            run_model(1'($urandom), 3'($urandom), 32'($urandom_range(0, 4*D + 7)),
                      $urandom, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
